// File: rtl/router_config_scheduler.sv
// Round-robin scheduler: grants one of three requesters, pushes its config word
// to the router, then waits for the expected number of output beats or a timeout.
module router_config_scheduler #(
  parameter int unsigned CONFIG_BIT_WIDTH = 30,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CONFIG_BIT_WIDTH-1:0] req_config_data_0,
  input  logic [CONFIG_BIT_WIDTH-1:0] req_config_data_1,
  input  logic [CONFIG_BIT_WIDTH-1:0] req_config_data_2,
  input  logic                        req_valid_0,
  input  logic                        req_valid_1,
  input  logic                        req_valid_2,
  output logic                        req_ready_0,
  output logic                        req_ready_1,
  output logic                        req_ready_2,
  output logic [CONFIG_BIT_WIDTH-1:0] m_axi_config_data,
  output logic                        m_axi_config_valid,
  input  logic                        m_axi_config_ready,
  input  logic                        mon_valid_1,
  input  logic                        mon_valid_2,
  input  logic                        mon_valid_3,
  input  logic                        mon_ready_1,
  input  logic                        mon_ready_2,
  input  logic                        mon_ready_3,
  output logic                        done_valid,
  output logic [1:0]                  done_id,
  output logic                        done_error,
  output logic                        busy
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CALC,
    WAIT_DONE,
    REPORT
  } state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    last_grant_q, last_grant_d;
  logic [1:0]                    job_id_q, job_id_d;
  logic [CONFIG_BIT_WIDTH-1:0]   cfg_q, cfg_d;
  logic                          cfg_valid_q, cfg_valid_d;
  logic [15:0]                   expected_q, expected_d;
  logic [15:0]                   beat_cnt_q, beat_cnt_d;
  logic [15:0]                   idle_cnt_q, idle_cnt_d;
  logic                          done_valid_q, done_valid_d;
  logic [1:0]                    done_id_q, done_id_d;
  logic                          done_error_q, done_error_d;

  logic [2:0]                    req_valid_vec;
  logic [CONFIG_BIT_WIDTH-1:0]   req_data [3];
  logic [1:0]                    pri0, pri1;
  logic                          grant_any;
  logic [1:0]                    grant_idx;
  logic [2:0]                    grant_vec;

  logic [4:0]                    sym1, sym2, sym3, prb1, prb2, prb3;
  logic [15:0]                   calc_sum;
  logic [1:0]                    beats_now;
  logic [16:0]                   beat_sum;

  assign req_valid_vec = {req_valid_2, req_valid_1, req_valid_0};
  assign req_data[0]   = req_config_data_0;
  assign req_data[1]   = req_config_data_1;
  assign req_data[2]   = req_config_data_2;

  // Priority order is last_grant+1, last_grant+2, last_grant (all mod 3).
  always_comb begin
    pri0      = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    pri1      = (pri0 == 2'd2) ? 2'd0 : pri0 + 2'd1;
    grant_any = 1'b1;
    grant_idx = '0;
    if (req_valid_vec[pri0]) begin
      grant_idx = pri0;
    end else if (req_valid_vec[pri1]) begin
      grant_idx = pri1;
    end else if (req_valid_vec[last_grant_q]) begin
      grant_idx = last_grant_q;
    end else begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant_vec = '0;
    if (state_q == IDLE && !reset && grant_any) begin
      grant_vec = 3'b001 << grant_idx;
    end
  end

  assign sym1 = cfg_q[CONFIG_BIT_WIDTH-1  -: 5];
  assign prb1 = cfg_q[CONFIG_BIT_WIDTH-6  -: 5];
  assign sym2 = cfg_q[CONFIG_BIT_WIDTH-11 -: 5];
  assign prb2 = cfg_q[CONFIG_BIT_WIDTH-16 -: 5];
  assign sym3 = cfg_q[CONFIG_BIT_WIDTH-21 -: 5];
  assign prb3 = cfg_q[CONFIG_BIT_WIDTH-26 -: 5];

  always_comb begin
    calc_sum = 16'(sym1) * 16'(prb1) * 16'd12
             + 16'(sym2) * 16'(prb2) * 16'd12
             + 16'(sym3) * 16'(prb3) * 16'd12;
  end

  assign beats_now = {1'b0, mon_valid_1 & mon_ready_1}
                   + {1'b0, mon_valid_2 & mon_ready_2}
                   + {1'b0, mon_valid_3 & mon_ready_3};
  assign beat_sum  = {1'b0, beat_cnt_q} + {15'd0, beats_now};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    job_id_d     = job_id_q;
    cfg_d        = cfg_q;
    cfg_valid_d  = cfg_valid_q;
    expected_d   = expected_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_error_d = done_error_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d      = ISSUE;
          last_grant_d = grant_idx;
          job_id_d     = grant_idx;
          cfg_d        = req_data[grant_idx];
          cfg_valid_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (m_axi_config_ready) begin
          state_d     = CALC;
          cfg_valid_d = 1'b0;
        end
      end
      CALC: begin
        expected_d = calc_sum;
        beat_cnt_d = '0;
        idle_cnt_d = '0;
        if (calc_sum == '0) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_id_d    = job_id_q;
          done_error_d = 1'b0;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        beat_cnt_d = beat_sum[15:0];
        idle_cnt_d = (beats_now != '0) ? '0 : idle_cnt_q + 16'd1;
        // Completion is tested first so it wins over a coincident timeout.
        if (beat_sum >= {1'b0, expected_q}) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_id_d    = job_id_q;
          done_error_d = 1'b0;
        end else if (idle_cnt_d >= TIMEOUT_LIMIT) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_id_d    = job_id_q;
          done_error_d = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd2;
      job_id_q     <= '0;
      cfg_q        <= '0;
      cfg_valid_q  <= 1'b0;
      expected_q   <= '0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      job_id_q     <= job_id_d;
      cfg_q        <= cfg_d;
      cfg_valid_q  <= cfg_valid_d;
      expected_q   <= expected_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_error_q <= done_error_d;
    end
  end

  assign req_ready_0        = grant_vec[0];
  assign req_ready_1        = grant_vec[1];
  assign req_ready_2        = grant_vec[2];
  assign m_axi_config_data  = cfg_q;
  assign m_axi_config_valid = cfg_valid_q;
  assign done_valid         = done_valid_q;
  assign done_id            = done_id_q;
  assign done_error         = done_error_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_router_config_scheduler.sv
// Directed bench for router_config_scheduler with a job-level reference model
// checked every cycle plus hand-computed latency/ordering expectations.
module tb_router_config_scheduler;

  localparam int W  = 30;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] req_config_data_0, req_config_data_1, req_config_data_2;
  logic         req_valid_0, req_valid_1, req_valid_2;
  logic         req_ready_0, req_ready_1, req_ready_2;
  logic [W-1:0] m_axi_config_data;
  logic         m_axi_config_valid, m_axi_config_ready;
  logic         mon_valid_1, mon_valid_2, mon_valid_3;
  logic         mon_ready_1, mon_ready_2, mon_ready_3;
  logic         done_valid;
  logic [1:0]   done_id;
  logic         done_error;
  logic         busy;

  router_config_scheduler #(
    .CONFIG_BIT_WIDTH(W),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_config_data_0 (req_config_data_0),
    .req_config_data_1 (req_config_data_1),
    .req_config_data_2 (req_config_data_2),
    .req_valid_0       (req_valid_0),
    .req_valid_1       (req_valid_1),
    .req_valid_2       (req_valid_2),
    .req_ready_0       (req_ready_0),
    .req_ready_1       (req_ready_1),
    .req_ready_2       (req_ready_2),
    .m_axi_config_data (m_axi_config_data),
    .m_axi_config_valid(m_axi_config_valid),
    .m_axi_config_ready(m_axi_config_ready),
    .mon_valid_1       (mon_valid_1),
    .mon_valid_2       (mon_valid_2),
    .mon_valid_3       (mon_valid_3),
    .mon_ready_1       (mon_ready_1),
    .mon_ready_2       (mon_ready_2),
    .mon_ready_3       (mon_ready_3),
    .done_valid        (done_valid),
    .done_id           (done_id),
    .done_error        (done_error),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no event within cycle budget (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W-1:0] mk(input int s1, input int p1, input int s2,
                                      input int p2, input int s3, input int p3);
    return {5'(s1), 5'(p1), 5'(s2), 5'(p2), 5'(s3), 5'(p3)};
  endfunction

  // Reference arithmetic: extract each 5-bit field by shifting, sum sym*prb*12.
  function automatic int exp_beats(input logic [W-1:0] w);
    int s;
    s = 0;
    for (int n = 0; n < 3; n++) begin
      s += int'((w >> (25 - 10 * n)) & 30'h1f) * int'((w >> (20 - 10 * n)) & 30'h1f) * 12;
    end
    return s;
  endfunction

  function automatic int pick(input logic [2:0] v, input int last);
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (last + i) % 3;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Job-level model: one job record advanced once per clock.
  bit         started = 1'b0;
  bit         m_active, m_sent, m_calc, m_report;
  int         m_remaining, m_quiet, m_id, m_done_id;
  int         m_last = 2;
  bit         m_done_err;
  logic [W-1:0] m_cfg;

  task automatic finish_job(input bit e);
    m_report   = 1'b1;
    m_done_id  = m_id;
    m_done_err = e;
  endtask

  always @(posedge clk) begin
    logic [2:0] v;
    int g;
    int n;
    v = {req_valid_2, req_valid_1, req_valid_0};
    g = pick(v, m_last);
    n = int'(mon_valid_1 & mon_ready_1) + int'(mon_valid_2 & mon_ready_2)
      + int'(mon_valid_3 & mon_ready_3);
    started = 1'b1;
    if (reset) begin
      m_active = 0; m_sent = 0; m_calc = 0; m_report = 0;
      m_last = 2; m_cfg = '0; m_id = 0; m_done_id = 0; m_done_err = 0;
      m_remaining = 0; m_quiet = 0;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1; m_sent = 0; m_last = g; m_id = g;
        m_cfg = (g == 0) ? req_config_data_0 : (g == 1) ? req_config_data_1 : req_config_data_2;
      end
    end else if (!m_sent) begin
      if (m_axi_config_ready) begin
        m_sent = 1; m_calc = 1;
      end
    end else if (m_calc) begin
      m_calc = 0;
      m_remaining = exp_beats(m_cfg);
      m_quiet = 0;
      if (m_remaining == 0) finish_job(1'b0);
    end else if (m_report) begin
      m_report = 0;
      m_active = 0;
    end else begin
      m_remaining -= n;
      m_quiet = (n > 0) ? 0 : m_quiet + 1;
      if (m_remaining <= 0) finish_job(1'b0);
      else if (m_quiet >= TO) finish_job(1'b1);
    end
  end

  always @(negedge clk) begin
    logic [2:0] v;
    int g;
    if (started) begin
      v = {req_valid_2, req_valid_1, req_valid_0};
      g = pick(v, m_last);
      chk("req_ready_0", req_ready_0, 32'(!reset && !m_active && g == 0));
      chk("req_ready_1", req_ready_1, 32'(!reset && !m_active && g == 1));
      chk("req_ready_2", req_ready_2, 32'(!reset && !m_active && g == 2));
      chk("busy", busy, 32'(m_active));
      chk("cfg_valid", m_axi_config_valid, 32'(m_active && !m_sent));
      chk("cfg_data", m_axi_config_data, 32'(m_cfg));
      chk("done_valid", done_valid, 32'(m_report));
      chk("done_id", done_id, 32'(m_done_id));
      chk("done_error", done_error, 32'(m_done_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mon(input logic [2:0] v, input logic [2:0] r);
    {mon_valid_3, mon_valid_2, mon_valid_1} = v;
    {mon_ready_3, mon_ready_2, mon_ready_1} = r;
  endtask

  task automatic wait_grant(output int k, output int c);
    k = -1;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready_0 | req_ready_1 | req_ready_2) begin
        chk("grant_onehot", 32'($countones({req_ready_2, req_ready_1, req_ready_0})), 1);
        k = req_ready_0 ? 0 : req_ready_1 ? 1 : 2;
        c = cyc;
        return;
      end
    end
    bound_fail("grant_wait");
  endtask

  task automatic wait_handshake(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_axi_config_valid && m_axi_config_ready) begin
        c = cyc;
        return;
      end
    end
    bound_fail("handshake_wait");
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_valid) begin
        c = cyc;
        return;
      end
    end
    bound_fail("done_wait");
  endtask

  initial begin
    int k, gc, hc, dc, last_beat, prev_dc;
    int grants [4];
    logic [2:0] v, r;
    logic [W-1:0] w;

    reset = 1'b1;
    req_config_data_0 = '0; req_config_data_1 = '0; req_config_data_2 = '0;
    req_valid_0 = 0; req_valid_1 = 0; req_valid_2 = 0;
    m_axi_config_ready = 0;
    set_mon(3'b000, 3'b000);

    chk("model_exp_72", 32'(exp_beats(mk(2, 1, 2, 1, 2, 1))), 72);
    chk("model_exp_max", 32'(exp_beats(mk(31, 31, 31, 31, 31, 31))), 34596);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_valid", m_axi_config_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_cfg_data", m_axi_config_data, 0);

    // Single job, 72 beats one per cycle rotating over the ports.
    step();
    req_config_data_0 = mk(2, 1, 2, 1, 2, 1);
    req_valid_0 = 1;
    m_axi_config_ready = 1;
    wait_grant(k, gc);
    chk("t1_grant", 32'(k), 0);
    step();
    req_valid_0 = 0;
    wait_handshake(hc);
    chk("t1_arb_latency", 32'(hc - gc), 1);
    step();
    set_mon(3'b111, 3'b111);
    step();
    last_beat = -1;
    for (int b = 0; b < 72; b++) begin
      int p;
      p = b % 3;
      v = 3'(1 << p) | 3'(1 << ((p + 1) % 3));
      r = 3'(1 << p) | 3'(1 << ((p + 2) % 3));
      set_mon(v, r);
      last_beat = cyc;
      step();
    end
    set_mon(3'b000, 3'b000);
    wait_done(dc);
    chk("t1_done_latency", 32'(dc - last_beat), 1);
    chk("t1_done_id", done_id, 0);
    chk("t1_done_error", done_error, 0);

    // Fresh reset, all requesters held: zero-expectation jobs back to back.
    step();
    reset = 1;
    step();
    reset = 0;
    req_config_data_0 = mk(1, 0, 0, 0, 0, 0);
    req_config_data_1 = mk(0, 5, 0, 0, 0, 0);
    req_config_data_2 = mk(0, 0, 7, 0, 31, 0);
    req_valid_0 = 1; req_valid_1 = 1; req_valid_2 = 1;
    m_axi_config_ready = 1;
    prev_dc = -1;
    for (int j = 0; j < 4; j++) begin
      wait_grant(k, gc);
      grants[j] = k;
      if (j > 0) chk("t2_back_to_back", 32'(gc - prev_dc), 1);
      if (j == 3) begin
        step();
        req_valid_0 = 0; req_valid_1 = 0; req_valid_2 = 0;
      end
      wait_handshake(hc);
      chk("t2_arb_latency", 32'(hc - gc), 1);
      wait_done(dc);
      chk("t2_zero_cfg_done", 32'(dc - hc), 2);
      prev_dc = dc;
    end
    chk("t2_grant0", 32'(grants[0]), 0);
    chk("t2_grant1", 32'(grants[1]), 1);
    chk("t2_grant2", 32'(grants[2]), 2);
    chk("t2_grant3", 32'(grants[3]), 0);

    // Router stalls 10 cycles, then expected 12 with only 5 beats -> timeout.
    step();
    w = mk(1, 1, 0, 0, 0, 0);
    req_config_data_1 = w;
    req_valid_1 = 1;
    m_axi_config_ready = 0;
    wait_grant(k, gc);
    chk("t3_grant", 32'(k), 1);
    step();
    req_valid_1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", m_axi_config_valid, 1);
      chk("t3_stall_data", m_axi_config_data, 32'(w));
      @(posedge clk);
      #1;
    end
    m_axi_config_ready = 1;
    wait_handshake(hc);
    chk("t3_stall_handshake", 32'(hc - gc), 11);
    step();
    step();
    set_mon(3'b111, 3'b111);
    step();
    set_mon(3'b001, 3'b001);
    step();
    set_mon(3'b100, 3'b100);
    last_beat = cyc;
    step();
    set_mon(3'b000, 3'b000);
    wait_done(dc);
    chk("t3_timeout_latency", 32'(dc - last_beat), 17);
    chk("t3_done_id", done_id, 1);
    chk("t3_done_error", done_error, 1);

    // Overshoot: expected 12, beats 2+3+3+3+3.
    step();
    req_config_data_2 = mk(0, 0, 1, 1, 0, 0);
    req_valid_2 = 1;
    wait_grant(k, gc);
    chk("t4_grant", 32'(k), 2);
    step();
    req_valid_2 = 0;
    wait_handshake(hc);
    step();
    step();
    set_mon(3'b011, 3'b011);
    step();
    for (int i = 0; i < 4; i++) begin
      set_mon(3'b111, 3'b111);
      last_beat = cyc;
      step();
    end
    set_mon(3'b000, 3'b000);
    wait_done(dc);
    chk("t4_done_latency", 32'(dc - last_beat), 1);
    chk("t4_done_id", done_id, 2);
    chk("t4_done_error", done_error, 0);

    // Reset in the middle of WAIT_DONE.
    step();
    req_config_data_1 = mk(2, 1, 2, 1, 2, 1);
    req_valid_1 = 1;
    wait_grant(k, gc);
    chk("t5_grant", 32'(k), 1);
    step();
    req_valid_1 = 0;
    wait_handshake(hc);
    step();
    step();
    set_mon(3'b111, 3'b111);
    step();
    set_mon(3'b000, 3'b000);
    step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done_valid", done_valid, 0);
    chk("t5_rst_cfg_valid", m_axi_config_valid, 0);
    step();
    req_valid_0 = 1; req_valid_1 = 1; req_valid_2 = 1;
    wait_grant(k, gc);
    chk("t5_post_reset_grant", 32'(k), 0);
    step();
    req_valid_0 = 0; req_valid_1 = 0; req_valid_2 = 0;
    wait_done(dc);
    chk("t5_done_id", done_id, 0);
    chk("t5_done_error", done_error, 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
